// File: rtl/census3x3_window_if.sv
// ---------------------------------------------------------------------------
// census3x3_window_if
//   Stream bundle between the 3x3 window assembler, the census stage and the
//   matching stage.
//   master : drives the window beat (in_valid, sof, win_in), receives the
//            tagged census stream.
//   slave  : the census stage itself.
//   Signals
//     in_valid  window taps valid this cycle
//     sof       start of frame, qualified by in_valid
//     win_in    nine taps, tap k = 3*r + c at [k*DATA_WIDTH +: DATA_WIDTH]
//     census    8-bit census code of the centre pixel
//     out_valid census/coordinates valid
//     out_x     centre column
//     out_y     centre row
//     border    centre lies on the frame edge
//     eof       last pixel of the frame
// ---------------------------------------------------------------------------
interface census3x3_window_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 10
);
  logic                    in_valid;
  logic                    sof;
  logic [9*DATA_WIDTH-1:0] win_in;
  logic [7:0]              census;
  logic                    out_valid;
  logic [COORD_WIDTH-1:0]  out_x;
  logic [COORD_WIDTH-1:0]  out_y;
  logic                    border;
  logic                    eof;

  modport master (
    output in_valid, sof, win_in,
    input  census, out_valid, out_x, out_y, border, eof
  );

  modport slave (
    input  in_valid, sof, win_in,
    output census, out_valid, out_x, out_y, border, eof
  );
endinterface

// File: rtl/census3x3_window.sv
// ---------------------------------------------------------------------------
// census3x3_window
//   Two-stage census transform on a 3x3 window. Tracks the image coordinate
//   of the window centre, compares the eight neighbours against the centre,
//   forces border pixels to code 8'h00 and emits a coordinate-tagged stream.
//   No back-pressure; one beat per cycle.
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    census3x3_window_if.slave (window in, tagged census out)
// ---------------------------------------------------------------------------
module census3x3_window #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int COORD_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  census3x3_window_if.slave     bus
);

  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMAGE_HEIGHT - 1);

  // Census bit position (MSB first) -> tap index; the centre (k=4) is skipped.
  localparam int TAP_OF_BIT [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  // Coordinate of the centre pixel the next in_valid beat will carry.
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;

  // Stage 1: raw compare bits plus tag.
  logic                   s1_valid_q;
  logic [7:0]             s1_cmp_q;
  logic [COORD_WIDTH-1:0] s1_x_q, s1_y_q;
  logic                   s1_border_q, s1_eof_q;

  // Stage 2: registered outputs.
  logic                   out_valid_q;
  logic [7:0]             census_q;
  logic [COORD_WIDTH-1:0] out_x_q, out_y_q;
  logic                   border_q, eof_q;

  logic [DATA_WIDTH-1:0]  tap [9];
  logic [7:0]             cmp_bits;
  logic [COORD_WIDTH-1:0] tag_x, tag_y;
  logic                   tag_border, tag_eof;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      tap[k] = bus.win_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
    cmp_bits = '0;
    for (int b = 0; b < 8; b++) begin
      cmp_bits[7-b] = (tap[TAP_OF_BIT[b]] < tap[4]);
    end
  end

  // sof re-aligns the tag for this very beat; the counters then advance from
  // the tag, so a sof beat is followed by (1,0) with no dead cycle.
  always_comb begin
    tag_x      = bus.sof ? '0 : x_q;
    tag_y      = bus.sof ? '0 : y_q;
    tag_border = (tag_x == '0) || (tag_x == X_LAST) ||
                 (tag_y == '0) || (tag_y == Y_LAST);
    tag_eof    = (tag_x == X_LAST) && (tag_y == Y_LAST);
    x_d        = x_q;
    y_d        = y_q;
    if (bus.in_valid) begin
      if (tag_x == X_LAST) begin
        x_d = '0;
        y_d = (tag_y == Y_LAST) ? '0 : tag_y + 1'b1;
      end else begin
        x_d = tag_x + 1'b1;
        y_d = tag_y;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  // Datapath registers are reset as well: their reset value is visible on the
  // outputs and the downstream stage relies on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_cmp_q    <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_border_q <= 1'b0;
      s1_eof_q    <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cmp_q    <= cmp_bits;
        s1_x_q      <= tag_x;
        s1_y_q      <= tag_y;
        s1_border_q <= tag_border;
        s1_eof_q    <= tag_eof;
      end
    end
  end

  // Outputs update only on valid beats and otherwise hold the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      census_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      border_q    <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        census_q <= s1_border_q ? 8'h00 : s1_cmp_q;
        out_x_q  <= s1_x_q;
        out_y_q  <= s1_y_q;
        border_q <= s1_border_q;
        eof_q    <= s1_eof_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.census    = census_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.border    = border_q;
  assign bus.eof       = eof_q;

endmodule

// File: doc/census3x3_window.md
# census3x3_window

Census-transform stage that consumes the 3×3 pixel window assembled from three cascaded 3-tap row buffers. It tracks the image coordinate of the window centre, computes an 8-bit census code per valid beat, forces border pixels to a defined code, and emits a registered, coordinate-tagged stream to the disparity/matching stage. It is a 2-stage pipeline with no back-pressure.

## Interface
- DATA_WIDTH, 32: width of one pixel tap (unsigned).
- IMAGE_WIDTH, 640: pixels per row.
- IMAGE_HEIGHT, 480: rows per frame.
- COORD_WIDTH, 10: width of coordinate outputs; must hold IMAGE_WIDTH-1 and IMAGE_HEIGHT-1.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window taps valid this cycle.
- sof  in  1  start of frame; qualified by in_valid; this beat is pixel (0,0).
- win_in  in  9*DATA_WIDTH  window taps; tap k = 3*r + c at bits [k*DATA_WIDTH +: DATA_WIDTH]; r=0 top (oldest) row, c=0 leftmost (oldest) column; centre is k=4.
- census  out  8  census code of the centre pixel.
- out_valid  out  1  census/coords valid.
- out_x  out  COORD_WIDTH  centre column.
- out_y  out  COORD_WIDTH  centre row.
- border  out  1  centre lies on the frame edge.
- eof  out  1  asserted with the output beat of pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).

## Operation
- Coordinate counters x, y track the centre pixel of the current input beat. Each in_valid beat uses the current (x, y), then advances it.
- x increments on each in_valid beat. At IMAGE_WIDTH-1, x wraps to 0 and y increments.
- y wraps to 0 after IMAGE_HEIGHT-1, i.e. the next frame starts at (0,0) without sof.
- sof with in_valid: the beat is tagged (0,0) regardless of the counters, and the counters advance to (1,0). sof without in_valid is ignored.
- Census bits, MSB to LSB, correspond to taps k = 0,1,2,3,5,6,7,8. A bit is 1 iff tap < centre, unsigned compare. Equal values give 0.
- Border: x==0 or x==IMAGE_WIDTH-1 or y==0 or y==IMAGE_HEIGHT-1. On border beats census is forced to 8'h00 and border=1. Non-border beats have border=0.
- eof is 1 iff the tagged coordinate is (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
- Beats with in_valid=0 are bubbles:
  - counters hold;
  - the pipeline propagates valid=0;
  - census, out_x, out_y, border and eof hold their last value while out_valid=0.

## Timing
- Latency is exactly 2 cycles from an in_valid beat to its out_valid.
  - Stage 1 registers the 8 compare bits, the tagged x/y, the border flag and the eof flag.
  - Stage 2 applies the border mask and registers all outputs.
- Full throughput: one beat per cycle; back-to-back in_valid yields back-to-back out_valid.
- Reset (asynchronous, any time, including mid-frame): out_valid=0, census=0, out_x=0, out_y=0, border=0, eof=0; counters return to (0,0).
- In-flight beats are discarded. The first beat after reset is tagged (0,0) even without sof.
- sof mid-frame: the counters re-align immediately and in-flight beats still complete with their original tags.
- Row wrap and frame wrap happen in the same cycle as the consuming beat. There is no dead cycle.

## Test plan
- Reset, then drive in_valid=1, sof=1, all taps=5 → at cycle +2: out_valid=1, out_x=0, out_y=0, border=1, census=8'h00.
- Interior beat (x=1, y=1) with centre=100 and taps k0..k8 = 50,150,100,99,·,101,0,255,100 → census=8'b1001_0100, border=0.
- Stream a full 640×480 frame of random taps, compared against a reference model:
  - required: 307200 out_valid beats;
  - exactly one eof, at (639,479);
  - (639,y) is followed by (0,y+1);
  - border count = 2236;
  - the next beat without sof is tagged (0,0).
- Random in_valid gaps (≈30% bubbles) → output sequence identical to the gap-free run. Outputs hold while out_valid=0, and latency is always 2.
- Assert sof at pixel (200,37) → that beat is tagged (0,0), the next beat is (1,0), and earlier in-flight beats keep their original tags.
- Pulse rst_n low for 1 cycle at an asynchronous offset while out_valid=1:
  - all outputs are 0 immediately;
  - no stale beat appears after release;
  - the first new beat is tagged (0,0).
